// File: rtl/sccb_responder.sv
// sccb_responder: SCCB/I2C target. Answers one 7-bit device address, takes
// ADDR_BYTES register-address bytes (MSB first), then either writes incoming
// bytes to a register port or streams register contents back to the master.
// The register address auto-increments per data byte. No repeated START.
//
// Ports:
//   clk, rst        system clock, async active-high reset
//   scl_in, sda_in  bus lines (asynchronous, synchronized here)
//   sda_oe          1 = pull SDA low (open drain, never drives high)
//   reg_addr        current register address
//   reg_wdata       received data byte, valid with reg_we
//   reg_we          1-cycle write strobe
//   reg_rd          1-cycle read strobe (reg_rdata valid the following cycle)
//   reg_rdata       read data from the register store
//   busy            high from an address-matched START until STOP
module sccb_responder #(
  parameter logic [6:0] DEV_ADDR   = 7'h3C,
  parameter int         ADDR_BYTES = 2,
  localparam int        ADDR_W     = 8 * ADDR_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR_S, DEV_ACK, REG_ADDR, REG_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  // Synchronizers reset to 1 (idle bus) so release from reset never looks
  // like a START.
  logic scl_m_q, scl_s_q, scl_p_q;
  logic sda_m_q, sda_s_q, sda_p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_m_q <= 1'b1; scl_s_q <= 1'b1; scl_p_q <= 1'b1;
      sda_m_q <= 1'b1; sda_s_q <= 1'b1; sda_p_q <= 1'b1;
    end else begin
      scl_m_q <= scl_in;  scl_s_q <= scl_m_q; scl_p_q <= scl_s_q;
      sda_m_q <= sda_in;  sda_s_q <= sda_m_q; sda_p_q <= sda_s_q;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  // START/STOP need SCL high in both cycles, so an SDA edge coinciding with
  // an SCL edge is never taken as a bus condition.
  assign scl_rise  =  scl_s_q & ~scl_p_q;
  assign scl_fall  = ~scl_s_q &  scl_p_q;
  assign start_det =  scl_s_q &  scl_p_q &  sda_p_q & ~sda_s_q;
  assign stop_det  =  scl_s_q &  scl_p_q & ~sda_p_q &  sda_s_q;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic              pend_q, pend_d;     // byte done / master ACKed, act on next fall
  logic              rw_q, rw_d;
  logic [6:0]        shreg_q, shreg_d;
  logic [7:0]        tx_q, tx_d;
  logic              sda_oe_q, sda_oe_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_rd_q, reg_rd_d;
  logic              cap_q, cap_d;       // reg_rdata valid this cycle
  logic              inc_q, inc_d;       // post-write address increment
  logic              busy_q, busy_d;
  logic [7:0]        rx_byte;
  logic              last_addr_byte;

  assign rx_byte        = {shreg_q, sda_s_q};
  assign last_addr_byte = (byte_cnt_q == 2'(ADDR_BYTES));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_cnt_d  = byte_cnt_q;
    pend_d      = pend_q;
    rw_d        = rw_q;
    shreg_d     = shreg_q;
    tx_d        = tx_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_rd_d    = 1'b0;
    cap_d       = reg_rd_q;
    inc_d       = reg_we_q;
    busy_d      = busy_q;

    if (cap_q) tx_d = reg_rdata;
    if (inc_q) reg_addr_d = reg_addr_q + ADDR_W'(1);

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      pend_d   = 1'b0;
    end else if (start_det) begin
      state_d    = DEV_ADDR_S;
      cnt_d      = 3'd0;
      byte_cnt_d = 2'd0;
      pend_d     = 1'b0;
      sda_oe_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        DEV_ADDR_S: begin
          if (scl_rise) begin
            shreg_d = rx_byte[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rw_d = sda_s_q;
              if (rx_byte[7:1] == DEV_ADDR) pend_d = 1'b1;
              else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end
          end else if (scl_fall && pend_q) begin
            pend_d   = 1'b0;
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            state_d  = DEV_ACK;
          end
        end
        DEV_ACK: if (scl_fall) begin
          sda_oe_d   = 1'b0;
          state_d    = REG_ADDR;
          cnt_d      = 3'd0;
          byte_cnt_d = 2'd0;
        end
        REG_ADDR: begin
          if (scl_rise) begin
            // Shifting the whole address leaves it MSB-byte-first after the last byte.
            reg_addr_d = {reg_addr_q[ADDR_W-2:0], sda_s_q};
            cnt_d      = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              pend_d     = 1'b1;
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end else if (scl_fall && pend_q) begin
            pend_d   = 1'b0;
            sda_oe_d = 1'b1;
            state_d  = REG_ACK;
          end
        end
        REG_ACK: begin
          if (scl_rise && last_addr_byte && rw_q) reg_rd_d = 1'b1;
          if (scl_fall) begin
            cnt_d = 3'd0;
            if (!last_addr_byte) begin
              sda_oe_d = 1'b0;
              state_d  = REG_ADDR;
            end else if (rw_q) begin
              sda_oe_d = ~tx_q[7];
              state_d  = RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shreg_d = rx_byte[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              reg_we_d    = 1'b1;
              reg_wdata_d = rx_byte;
              pend_d      = 1'b1;
            end
          end else if (scl_fall && pend_q) begin
            pend_d   = 1'b0;
            sda_oe_d = 1'b1;
            state_d  = WR_ACK;
          end
        end
        WR_ACK: if (scl_fall) begin
          sda_oe_d = 1'b0;
          cnt_d    = 3'd0;
          state_d  = WR_DATA;
        end
        RD_DATA: if (scl_fall) begin
          // Entered with bit 7 already on the bus; each fall ends one bit.
          if (cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
            state_d  = RD_ACK;
          end else begin
            cnt_d    = cnt_q + 3'd1;
            tx_d     = {tx_q[6:0], 1'b0};
            sda_oe_d = ~tx_q[6];
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s_q) begin
              reg_addr_d = reg_addr_q + ADDR_W'(1);
              reg_rd_d   = 1'b1;
              pend_d     = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end else if (scl_fall && pend_q) begin
            pend_d   = 1'b0;
            sda_oe_d = ~tx_q[7];
            cnt_d    = 3'd0;
            state_d  = RD_DATA;
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      byte_cnt_q  <= 2'd0;
      pend_q      <= 1'b0;
      rw_q        <= 1'b0;
      shreg_q     <= 7'd0;
      tx_q        <= 8'd0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'd0;
      reg_we_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      cap_q       <= 1'b0;
      inc_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      pend_q      <= pend_d;
      rw_q        <= rw_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_rd_q    <= reg_rd_d;
      cap_q       <= cap_d;
      inc_q       <= inc_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_rd    = reg_rd_q;
  assign busy      = busy_q;

endmodule
